// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding and scoreboard slot.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // One in-flight producer: write-back enable, memory-read (load) flag, destination.
    typedef struct packed {
        logic       wb;
        logic       mr;
        logic [3:0] dest;
    } slot_t;

    localparam int    SLOT_W = 6;
    localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one scoreboard slot against the decode-stage source registers.
module hazard_match
    import hazard_pkg::*;
(
    input  slot_t      slot,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       two_src,
    output logic       hit
);

    logic m1;
    logic m2;

    // A bubble never matches because its wb bit is zero; all 4 dest bits compare.
    always_comb begin
        m1  = slot.wb & (slot.dest == src1);
        m2  = two_src & slot.wb & (slot.dest == src2);
        hit = m1 | m2;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard control: shadow EXE/MEM scoreboard, stall/flush sequencing,
// and saturating perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             Two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [3:0]       id_dest,
    input  logic             id_valid,
    input  logic             branch_taken,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               REM_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    slot_t            exe_slot;
    slot_t            mem_slot;
    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] flush_rem;
    logic [REM_W-1:0] flush_rem_nxt;
    logic             exe_hit;
    logic             mem_hit;
    logic             raw_haz;

    hazard_match u_exe_match (
        .slot    (exe_slot),
        .src1    (src1),
        .src2    (src2),
        .two_src (Two_src),
        .hit     (exe_hit)
    );

    hazard_match u_mem_match (
        .slot    (mem_slot),
        .src1    (src1),
        .src2    (src2),
        .two_src (Two_src),
        .hit     (mem_hit)
    );

    // With forwarding only a load still in EXE blocks; otherwise any producer in EXE or MEM does.
    always_comb begin
        raw_haz = fwd_en ? (exe_hit & exe_slot.mr) : (exe_hit | mem_hit);
        flush   = branch_taken | (state == FLUSH);
        hazard  = flush | (raw_haz & id_valid);
        freeze  = raw_haz & id_valid & ~flush;
    end

    // Shadow scoreboard: a stalled or flushed decode slot enters EXE as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_slot <= BUBBLE;
            mem_slot <= BUBBLE;
        end else begin
            mem_slot <= exe_slot;
            if (hazard | flush | ~id_valid)
                exe_slot <= BUBBLE;
            else
                exe_slot <= '{wb: id_wb_en, mr: id_mem_r_en, dest: id_dest};
        end
    end

    // State and flush countdown registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_rem <= '0;
        end else begin
            state     <= state_nxt;
            flush_rem <= flush_rem_nxt;
        end
    end

    // Next state: a taken branch (re)starts the flush from any state.
    always_comb begin
        state_nxt     = state;
        flush_rem_nxt = flush_rem;
        if (branch_taken) begin
            state_nxt     = FLUSH;
            flush_rem_nxt = REM_INIT;
        end else begin
            case (state)
                FLUSH: begin
                    if (flush_rem == '0)
                        state_nxt = RUN;
                    else
                        flush_rem_nxt = flush_rem - 1'b1;
                end
                default: state_nxt = raw_haz ? STALL : RUN;
            endcase
        end
    end

    // Saturating perf counters: freeze cycles and taken branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (freeze && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (branch_taken && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with CNT_W=2 checks saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en;
    logic [3:0]  src1, src2, id_dest;
    logic        Two_src, id_wb_en, id_mem_r_en, id_valid, branch_taken;
    logic        hazard, freeze, flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        hazard2, freeze2, flush2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .src1(src1), .src2(src2), .Two_src(Two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .id_valid(id_valid),
        .branch_taken(branch_taken), .hazard(hazard), .freeze(freeze), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .src1(src1), .src2(src2), .Two_src(Two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .id_valid(id_valid),
        .branch_taken(branch_taken), .hazard(hazard2), .freeze(freeze2), .flush(flush2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    // Drive one decode-slot vector.
    task automatic drv(input logic v, input logic wb, input logic mr, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic two, input logic br);
        id_valid = v; id_wb_en = wb; id_mem_r_en = mr; id_dest = d;
        src1 = s1; src2 = s2; Two_src = two; branch_taken = br;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; fwd_en = 1'b0; idle();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({hazard, freeze, flush} !== 3'b000)
            $display("FAIL reset_outs: got %b expected 000", {hazard, freeze, flush});
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL reset_cnts: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_fwd();
        fwd_en = 1'b0;
        drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);      // ADD R1
        #1; chk_cnt++;
        if (hazard !== 1'b0) $display("FAIL nofwd_issue: hazard got %b expected 0", hazard);
        else pass_cnt++;
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0);      // consumer src1=R1
        for (int c = 0; c < 2; c++) begin
            #1; chk_cnt++;
            if ({hazard, freeze} !== 2'b11)
                $display("FAIL nofwd_stall%0d: hz/fz got %b expected 11", c, {hazard, freeze});
            else pass_cnt++;
            @(negedge clk);
        end
        #1; chk_cnt++;
        if ({hazard, freeze} !== 2'b00)
            $display("FAIL nofwd_release: hz/fz got %b expected 00", {hazard, freeze});
        else pass_cnt++;
        @(negedge clk);
        idle();
        exp_stall = 2;
        chk_cnt++;
        if (stall_cnt !== 16'(exp_stall))
            $display("FAIL nofwd_cnt: stall_cnt got %0d expected %0d", stall_cnt, exp_stall);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fwd();
        fwd_en = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);      // ADD R1
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        #1; chk_cnt++;
        if (hazard !== 1'b0) $display("FAIL fwd_alu_exe: hazard got %b expected 0", hazard);
        else pass_cnt++;
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);      // LDR R2
        #1; chk_cnt++;
        if (hazard !== 1'b0) $display("FAIL fwd_alu_mem: hazard got %b expected 0", hazard);
        else pass_cnt++;
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0);      // use R2 as src2
        #1; chk_cnt++;
        if ({hazard, freeze} !== 2'b11)
            $display("FAIL fwd_load_use: hz/fz got %b expected 11", {hazard, freeze});
        else pass_cnt++;
        @(negedge clk);
        #1; chk_cnt++;
        if ({hazard, freeze} !== 2'b00)
            $display("FAIL fwd_load_release: hz/fz got %b expected 00", {hazard, freeze});
        else pass_cnt++;
        @(negedge clk);
        idle();
        exp_stall = 3;
        chk_cnt++;
        if (stall_cnt !== 16'(exp_stall))
            $display("FAIL fwd_cnt: stall_cnt got %0d expected %0d", stall_cnt, exp_stall);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_src();
        fwd_en = 1'b0;
        drv(1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);      // producer R5
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
        #1; chk_cnt++;
        if (hazard !== 1'b0) $display("FAIL two_src_off: hazard got %b expected 0", hazard);
        else pass_cnt++;
        Two_src = 1'b1;
        #1; chk_cnt++;
        if (hazard !== 1'b1) $display("FAIL two_src_on: hazard got %b expected 1", hazard);
        else pass_cnt++;
        exp_stall++;
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_branch();
        drv(1'b1, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0, 1'b0, 1'b1);
        #1; chk_cnt++;
        if ({hazard, freeze, flush} !== 3'b101)
            $display("FAIL br_cycle: hz/fz/fl got %b expected 101", {hazard, freeze, flush});
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1; chk_cnt++;
        if ({hazard, freeze, flush} !== 3'b101)
            $display("FAIL br_extra: hz/fz/fl got %b expected 101", {hazard, freeze, flush});
        else pass_cnt++;
        chk_cnt++;
        if (dut.exe_slot !== 6'd0) $display("FAIL br_bubble: exe_slot got %h expected 00", dut.exe_slot);
        else pass_cnt++;
        @(negedge clk);
        #1; chk_cnt++;
        if ({hazard, freeze, flush} !== 3'b000)
            $display("FAIL br_done: hz/fz/fl got %b expected 000", {hazard, freeze, flush});
        else pass_cnt++;
        chk_cnt++;
        if (flush_cnt !== 16'd1) $display("FAIL br_cnt: flush_cnt got %0d expected 1", flush_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_haz_and_branch();
        fwd_en = 1'b0;
        drv(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 4'd0, 1'b0, 1'b1);
        #1; chk_cnt++;
        if ({hazard, freeze, flush} !== 3'b101)
            $display("FAIL hzbr_outs: hz/fz/fl got %b expected 101", {hazard, freeze, flush});
        else pass_cnt++;
        @(negedge clk);
        idle();
        chk_cnt++;
        if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'd2)
            $display("FAIL hzbr_cnts: got %0d/%0d expected %0d/2", stall_cnt, flush_cnt, exp_stall);
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        idle(); rst = 1'b1;
        #1; chk_cnt++;
        if (flush !== 1'b1) $display("FAIL rstf_pre: flush got %b expected 1", flush);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1; chk_cnt++;
        if ({hazard, freeze, flush, stall_cnt, flush_cnt} !== 35'd0)
            $display("FAIL rstf_post: hz/fz/fl %b cnts %0d/%0d expected 000 0/0",
                     {hazard, freeze, flush}, stall_cnt, flush_cnt);
        else pass_cnt++;
        @(negedge clk);
        drv(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #1; chk_cnt++;
        if (freeze !== 1'b1) $display("FAIL rsts_pre: freeze got %b expected 1", freeze);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1; chk_cnt++;
        if ({hazard, freeze, flush, stall_cnt2, flush_cnt2} !== 7'd0)
            $display("FAIL rsts_post: hz/fz/fl %b cnts %0d/%0d expected 000 0/0",
                     {hazard, freeze, flush}, stall_cnt2, flush_cnt2);
        else pass_cnt++;
        idle();
        @(negedge clk);
    endtask

    task automatic test_saturate();
        fwd_en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            drv(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
            @(negedge clk);
            if (r == 2) begin idle(); @(negedge clk); end
            drv(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);
            repeat ((r == 2) ? 1 : 2) @(negedge clk);
            idle();
            repeat (2) @(negedge clk);
        end
        chk_cnt++;
        if (stall_cnt !== 16'd5) $display("FAIL sat_stall16: got %0d expected 5", stall_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (stall_cnt2 !== 2'd3) $display("FAIL sat_stall2: got %0d expected 3", stall_cnt2);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            drv(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
            @(negedge clk);
            idle();
            repeat (2) @(negedge clk);
        end
        chk_cnt++;
        if (flush_cnt !== 16'd4 || flush_cnt2 !== 2'd3)
            $display("FAIL sat_flush: got %0d/%0d expected 4/3", flush_cnt, flush_cnt2);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_no_fwd();
        test_fwd();
        test_two_src();
        test_branch();
        test_haz_and_branch();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
